// File: rtl/register_scoreboard_pkg.sv
// Shared sizing and types for the decode-stage register scoreboard.
package register_scoreboard_pkg;
  localparam int REGISTER_DEPTH = 32;
  localparam int MAX_INFLIGHT   = 3;
  localparam int ADDR_W         = $clog2(REGISTER_DEPTH);
  localparam int COUNT_W        = $clog2(MAX_INFLIGHT + 1);

  typedef logic [ADDR_W-1:0]  reg_addr_t;
  typedef logic [COUNT_W-1:0] scoreboard_count_t;
endpackage

// File: rtl/register_scoreboard_entry.sv
// Per-register saturating up/down count of pending writes.
module scoreboard_entry
  import register_scoreboard_pkg::*;
#(
  parameter int CNT_W = COUNT_W,
  parameter int MAX   = MAX_INFLIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero,
  output logic             o_full
);
  logic [CNT_W-1:0] r_count;
  logic             w_dec;
  logic             w_inc;

  assign o_zero  = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(MAX));
  assign o_count = r_count;

  // A retire against an empty counter is dropped; the top flags it.
  assign w_dec = i_dec && !o_zero;
  assign w_inc = i_inc && !(o_full && !w_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_count <= '0;
    else if (w_inc && !w_dec) r_count <= r_count + CNT_W'(1);
    else if (w_dec && !w_inc) r_count <= r_count - CNT_W'(1);
  end
endmodule

// File: rtl/register_scoreboard.sv
// In-order register scoreboard: gates decode issue on pending writes, retires on writeback.
module register_scoreboard #(
  parameter int REGISTER_DEPTH = register_scoreboard_pkg::REGISTER_DEPTH,
  parameter int MAX_INFLIGHT   = register_scoreboard_pkg::MAX_INFLIGHT,
  parameter bit WB_BYPASS      = 1'b1,
  localparam int AW = $clog2(REGISTER_DEPTH),
  localparam int CW = $clog2(MAX_INFLIGHT + 1),
  localparam int TW = $clog2(REGISTER_DEPTH * MAX_INFLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [AW-1:0]             issue_rs1,
  input  logic                      issue_rs1_used,
  input  logic [AW-1:0]             issue_rs2,
  input  logic                      issue_rs2_used,
  input  logic [AW-1:0]             issue_rd,
  input  logic                      issue_rd_write,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_rd,
  output logic                      stall_decode,
  output logic [REGISTER_DEPTH-1:0] busy,
  output logic [TW-1:0]             inflight_total,
  output logic                      underflow_error
);
  logic [REGISTER_DEPTH-1:0][CW-1:0] w_count;
  logic [REGISTER_DEPTH-1:0]         w_zero;
  logic [REGISTER_DEPTH-1:0]         w_full;
  logic                              w_rs1_busy;
  logic                              w_rs2_busy;
  logic                              w_rd_block;
  logic                              w_fire;
  logic                              w_tot_inc;
  logic                              w_tot_dec;
  logic                              w_underflow;
  logic [TW-1:0]                     r_total;
  logic                              r_err;

  // x0 is hardwired zero: never busy, never counted.
  assign w_count[0] = '0;
  assign w_zero[0]  = 1'b1;
  assign w_full[0]  = 1'b0;

  for (genvar r = 1; r < REGISTER_DEPTH; r++) begin : g_entry
    logic w_inc;
    logic w_dec;
    assign w_inc = w_fire && issue_rd_write && (issue_rd == AW'(r));
    assign w_dec = wb_valid && (wb_rd == AW'(r));
    scoreboard_entry #(.CNT_W(CW), .MAX(MAX_INFLIGHT)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .o_count (w_count[r]),
      .o_zero  (w_zero[r]),
      .o_full  (w_full[r])
    );
  end

  // With bypass, the last pending write retiring this cycle resolves the source now.
  assign w_rs1_busy = (issue_rs1 != '0) && !w_zero[issue_rs1] &&
                      !(WB_BYPASS && (w_count[issue_rs1] == CW'(1)) &&
                        wb_valid && (wb_rd == issue_rs1));
  assign w_rs2_busy = (issue_rs2 != '0) && !w_zero[issue_rs2] &&
                      !(WB_BYPASS && (w_count[issue_rs2] == CW'(1)) &&
                        wb_valid && (wb_rd == issue_rs2));
  assign w_rd_block = issue_rd_write && (issue_rd != '0) && w_full[issue_rd] &&
                      !(wb_valid && (wb_rd == issue_rd));

  assign issue_ready  = !(issue_rs1_used && w_rs1_busy) &&
                        !(issue_rs2_used && w_rs2_busy) && !w_rd_block;
  assign w_fire       = issue_valid && issue_ready;
  assign stall_decode = issue_valid && !issue_ready;

  assign w_tot_inc   = w_fire && issue_rd_write && (issue_rd != '0);
  assign w_tot_dec   = wb_valid && (wb_rd != '0) && !w_zero[wb_rd];
  assign w_underflow = wb_valid && (wb_rd != '0) && w_zero[wb_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total <= '0;
      r_err   <= 1'b0;
    end else begin
      r_total <= r_total + TW'(w_tot_inc) - TW'(w_tot_dec);
      if (w_underflow) r_err <= 1'b1;
    end
  end

  assign busy            = ~w_zero;
  assign inflight_total  = r_total;
  assign underflow_error = r_err;
endmodule

// File: tb/tb_register_scoreboard.sv
// Scoreboard bench: stimulus pushes expectations, negedge monitor pops and compares.
module tb_register_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 0, issue_rs1_used = 0, issue_rs2_used = 0, issue_rd_write = 0;
  logic [4:0]  issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_rd = 0;
  logic        wb_valid = 0;
  logic        rdy1, rdy0, stall1, stall0, err1, err0;
  logic [31:0] busy1, busy0;
  logic [6:0]  tot1, tot0;

  typedef struct {
    int          id;
    logic        rdy1;
    logic        rdy0;
    logic        stall;
    logic [31:0] busy;
    logic [6:0]  total;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  register_scoreboard #(.REGISTER_DEPTH(32), .MAX_INFLIGHT(3), .WB_BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy1),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_decode(stall1),
    .busy(busy1), .inflight_total(tot1), .underflow_error(err1));

  register_scoreboard #(.REGISTER_DEPTH(32), .MAX_INFLIGHT(3), .WB_BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy0),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_decode(stall0),
    .busy(busy0), .inflight_total(tot0), .underflow_error(err0));

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL step%0d %s: got %h want %h", id, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ready_byp",  e.id, 32'(rdy1),   32'(e.rdy1));
      chk("ready_nobyp", e.id, 32'(rdy0),  32'(e.rdy0));
      chk("stall",      e.id, 32'(stall1), 32'(e.stall));
      chk("busy",       e.id, busy1,       e.busy);
      chk("busy_nobyp", e.id, busy0,       e.busy);
      chk("total",      e.id, 32'(tot1),   32'(e.total));
      chk("underflow",  e.id, 32'(err1),   32'(e.err));
    end
  end

  int sid = 0;
  task automatic step(input logic r, input logic v,
                      input int rs1, input logic u1, input int rs2, input logic u2,
                      input int rd, input logic w, input logic wbv, input int wbrd,
                      input logic er1, input logic er0, input logic [31:0] eb,
                      input int et, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; issue_valid = v;
    issue_rs1 = 5'(rs1); issue_rs1_used = u1;
    issue_rs2 = 5'(rs2); issue_rs2_used = u2;
    issue_rd = 5'(rd); issue_rd_write = w;
    wb_valid = wbv; wb_rd = 5'(wbrd);
    e.id = sid; e.rdy1 = er1; e.rdy0 = er0; e.stall = v && !er1;
    e.busy = eb; e.total = 7'(et); e.err = ee;
    q.push_back(e);
    sid++;
  endtask

  localparam logic [31:0] B4 = 32'h10;
  localparam logic [31:0] B5 = 32'h20;
  localparam logic [31:0] B7 = 32'h80;

  initial begin
    //    rst v  rs1 u1 rs2 u2 rd w  wbv wbrd  rdy1 rdy0 busy    tot err
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0,       0, 0);  // during reset
    step(0, 1, 1, 1, 0, 0, 5, 1, 0, 0,   1, 1, 0,       0, 0);  // issue add x5
    step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0,   0, 0, B5,      1, 0);  // dependent stalls
    step(0, 0, 5, 1, 0, 0, 0, 0, 1, 5,   1, 0, B5,      1, 0);  // wb 5: bypass only
    step(0, 1, 5, 1, 0, 0, 0, 1, 0, 0,   1, 1, 0,       0, 0);  // rd=0 write issue
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0,       0, 0);  // wb to x0
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   1, 1, 0,       0, 0);  // x7 #1
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   1, 1, B7,      1, 0);  // x7 #2
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   1, 1, B7,      2, 0);  // x7 #3
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, B7,      3, 0);  // x7 #4 saturated
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 7,   1, 1, B7,      3, 0);  // x7 #4 + wb 7
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, B7,      3, 0);  // still full
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   1, 1, B7,      3, 0);  // wb 9 at zero
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, B7,      3, 1);  // error sticky
    step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0,   1, 1, B7,      3, 1);  // issue x4
    step(0, 1, 0, 0, 0, 0, 4, 1, 1, 4,   1, 1, B4 | B7, 4, 1);  // issue+wb x4
    step(0, 0, 0, 0, 4, 1, 0, 0, 1, 4,   1, 0, B4 | B7, 4, 1);  // rs2 bypass
    step(0, 0, 0, 0, 4, 1, 0, 0, 0, 0,   1, 1, B7,      3, 1);  // no-bypass rises
    step(0, 0, 7, 1, 0, 0, 0, 0, 1, 7,   0, 0, B7,      3, 1);  // count>1: no bypass
    step(1, 0, 7, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0,       0, 0);  // async reset mid-op
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   1, 1, 0,       0, 0);  // stale wb after reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0,       0, 1);  // flagged
    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

In-order scoreboard that gates the decode stage's register-file reads against pending writes. It tracks, per architectural register, how many issued instructions will still write it, and withholds `issue_ready` while a source or destination of the instruction in decode is unresolved. Writeback retires entries. It sits beside the decode stage, between the fetch-to-decode handshake and the register-file read ports.

## Interface
Parameters:
- `REGISTER_DEPTH`, 32 — architectural registers; register 0 is hardwired zero and never tracked.
- `MAX_INFLIGHT`, 3 — maximum in-flight writes per register; counter width is `$clog2(MAX_INFLIGHT+1)`.
- `WB_BYPASS`, 1 — 1: a register whose last pending write retires this cycle counts as ready.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset; one clock; asynchronous, active-high.
- `issue_valid` in 1 — decode holds a valid, non-dropped instruction.
- `issue_ready` out 1 — scoreboard permits issue this cycle.
- `issue_rs1` in `$clog2(REGISTER_DEPTH)` — source 1 address.
- `issue_rs1_used` in 1 — source 1 is read.
- `issue_rs2` in `$clog2(REGISTER_DEPTH)` — source 2 address.
- `issue_rs2_used` in 1 — source 2 is read.
- `issue_rd` in `$clog2(REGISTER_DEPTH)` — destination address.
- `issue_rd_write` in 1 — instruction writes `issue_rd`.
- `wb_valid` in 1 — writeback retires one register write.
- `wb_rd` in `$clog2(REGISTER_DEPTH)` — retired destination.
- `stall_decode` out 1 — `issue_valid && !issue_ready`.
- `busy` out `REGISTER_DEPTH` — bit r is set when count[r] != 0; bit 0 is always 0.
- `inflight_total` out `$clog2(REGISTER_DEPTH*MAX_INFLIGHT+1)` — sum of all counters.
- `underflow_error` out 1 — sticky; set when a writeback hits a zero counter.

## Operation
- State: `count[1..REGISTER_DEPTH-1]`, `inflight_total` register, `underflow_error` flag.
- Issue fires when `issue_valid && issue_ready`.
- `src_busy(r)` is true when r != 0 and count[r] != 0.
  - Exception when `WB_BYPASS`=1: false if count[r]==1 and `wb_valid && wb_rd==r`.
- `issue_ready` = !(`issue_rs1_used` && src_busy(rs1)) && !(`issue_rs2_used` && src_busy(rs2)) && !(`issue_rd_write` && rd!=0 && count[rd]==MAX_INFLIGHT && !(`wb_valid` && `wb_rd`==rd)).
  - Purely combinational from current state and inputs.
  - Independent of `issue_valid`.
- Counter update each cycle, for register r != 0:
  - inc = fire && `issue_rd_write` && rd==r.
  - dec = `wb_valid` && `wb_rd`==r && count[r]!=0.
  - count[r] += inc − dec. Simultaneous inc and dec leaves it unchanged.
- Writeback to r==0: ignored.
- Writeback to a zero counter: counter stays 0; `underflow_error` is set.
- Issue with rd==0 or `issue_rd_write`=0 changes no counter.
- `inflight_total` tracks the net increment/decrement with the same rules.
- `underflow_error` clears only on reset.

## Timing
- Reset values: all counters 0, `inflight_total`=0, `underflow_error`=0.
  - During reset, `issue_ready`=1 and `busy`=0.
- Asserting `rst` mid-operation clears all pending state immediately; in-flight writebacks arriving after reset set `underflow_error`.
- Issue → busy latency: 1 cycle. A dependent instruction in the next cycle stalls.
- Writeback → ready latency:
  - 0 cycles with `WB_BYPASS`=1.
  - 1 cycle with `WB_BYPASS`=0.
- Counter saturation: at MAX_INFLIGHT, a further write-issue to that rd stalls unless a same-rd writeback occurs that cycle.
- No combinational path from `issue_valid` to `issue_ready`.

## Structure
- Shared package holds:
  - `REGISTER_DEPTH`.
  - `reg_addr_t` typedef (`logic [$clog2(REGISTER_DEPTH)-1:0]`).
  - `scoreboard_count_t` typedef.
- One sub-module is natural: `scoreboard_entry` — a single saturating up/down counter with inc/dec/zero/full outputs, generated for registers 1..REGISTER_DEPTH-1.
- Top level holds the hazard compare, `inflight_total`, and the error flag.

## Test plan
- Reset then issue `add x5` (rd=5, write) → next cycle `busy[5]`=1 and `inflight_total`=1. An instruction reading rs1=5 sees `issue_ready`=0 and `stall_decode`=1. Writeback of 5 with `WB_BYPASS`=1 → same-cycle `issue_ready`=1.
- Same sequence with `WB_BYPASS`=0 → `issue_ready` rises one cycle after the writeback.
- Issue writing rd=0, and a writeback to rd=0 → `busy`=0, `inflight_total`=0, no error.
- Three issues to rd=7 (MAX=3) → count 3. A fourth issue stalls; a fourth issue plus a wb to 7 in the same cycle fires, and count stays 3.
- Writeback to rd=9 at count 0 → `underflow_error`=1 and stays set. Asserting `rst` mid-cycle clears error and counters asynchronously.
- Simultaneous issue rd=4 and writeback rd=4 with count 1 → count stays 1 and `inflight_total` unchanged.
